// File: rtl/sensor_sample_mux_if.sv
// ============================================================================
// Module   : sensor_sample_mux_if
// Purpose  : Handshake/bus bundle between a sample requester, the serial
//            sensor sources, the tx sequencer and sensor_sample_mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sensor_sample_mux_if #(
    parameter int NCH      = 4,
    parameter int SAMPLE_W = 16,
    parameter int SEL_W    = 2
);
    logic                start;
    logic [SEL_W-1:0]    chan_sel;
    logic                abort;
    logic [NCH-1:0]      sample_ctl;
    logic [NCH-1:0]      sample_clk;
    logic [NCH-1:0]      sample_datain;
    logic                bit_req;
    logic                bitsrc;
    logic                datadone;
    logic                busy;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic [SEL_W-1:0]    sample_chan;
    logic                sel_err;

    modport master (
        output start, chan_sel, abort, sample_datain, bit_req,
        input  sample_ctl, sample_clk, bitsrc, datadone, busy,
               sample_valid, sample_data, sample_chan, sel_err
    );

    modport slave (
        input  start, chan_sel, abort, sample_datain, bit_req,
        output sample_ctl, sample_clk, bitsrc, datadone, busy,
               sample_valid, sample_data, sample_chan, sel_err
    );
endinterface

`default_nettype wire

// File: rtl/sensor_sample_mux.sv
// ============================================================================
// Module   : sensor_sample_mux
// Purpose  : Captures one serial sample from a selected source and replays it
//            bit-serially to a tx sequencer. Option: SENSOR_SAMPLE_PARITY_EN
//            appends an even-parity bit after the LSB.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sensor_sample_mux #(
    parameter int NCH      = 4,
    parameter int SAMPLE_W = 16,
    parameter int CLKDIV   = 4,
    parameter int SEL_W    = (NCH > 2) ? $clog2(NCH) : 1
) (
    input wire                 clk,
    input wire                 reset,
    sensor_sample_mux_if.slave bus
);

    localparam int c_HALF  = CLKDIV / 2;
    localparam int c_DIV_W = $clog2(CLKDIV);
    localparam int c_CNT_W = $clog2(SAMPLE_W);
`ifdef SENSOR_SAMPLE_PARITY_EN
    localparam int c_NBITS = SAMPLE_W + 1;
`else
    localparam int c_NBITS = SAMPLE_W;
`endif
    localparam int c_TX_W  = $clog2(c_NBITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLKDIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_SHIFT = c_DIV_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(SAMPLE_W - 1);
    localparam logic [c_TX_W-1:0]  c_TX_LAST   = c_TX_W'(c_NBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [c_DIV_W-1:0]  div_q,     div_d;
    logic [c_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [c_TX_W-1:0]   tx_cnt_q,  tx_cnt_d;
    logic [c_NBITS-1:0]  tx_sr_q,   tx_sr_d;
    logic [SAMPLE_W-1:0] data_q,    data_d;
    logic [SEL_W-1:0]    chan_q,    chan_d;
    logic                valid_q,   valid_d;
    logic                done_q,    done_d;
    logic                sel_err_q, sel_err_d;

    logic                w_sel_ok;
    logic [NCH-1:0]      w_onehot;
    logic                w_din;
    logic [c_NBITS-1:0]  w_tx_load;

    assign w_sel_ok = (32'(bus.chan_sel) < 32'(NCH));
    assign w_onehot = NCH'(1) << chan_q;
    assign w_din    = bus.sample_datain[chan_q];

`ifdef SENSOR_SAMPLE_PARITY_EN
    assign w_tx_load = {data_q, ^data_q};
`else
    assign w_tx_load = data_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_cnt_q  <= '0;
            tx_sr_q   <= '0;
            data_q    <= '0;
            chan_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_sr_q   <= tx_sr_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        tx_sr_d   = tx_sr_q;
        data_d    = data_q;
        chan_d    = chan_q;
        valid_d   = valid_q;
        done_d    = done_q;
        sel_err_d = 1'b0;

        // abort wins over everything, including a coincident start
        if (bus.abort) begin
            state_d   = ST_IDLE;
            div_d     = '0;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            tx_sr_d   = '0;
            valid_d   = 1'b0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        if (w_sel_ok) begin
                            state_d   = ST_SETUP;
                            chan_d    = bus.chan_sel;
                            valid_d   = 1'b0;
                            done_d    = 1'b0;
                            div_d     = '0;
                            bit_cnt_d = '0;
                            tx_cnt_d  = '0;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (div_q == c_DIV_LAST) begin
                        div_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // capture on the last high cycle so the source has had the whole high phase to settle
                    if (div_q == c_DIV_SHIFT) begin
                        data_d = {data_q[SAMPLE_W-2:0], w_din};
                    end
                    if (div_q == c_DIV_LAST) begin
                        div_d = '0;
                        if (bit_cnt_q == c_BIT_LAST) begin
                            state_d  = ST_HOLD;
                            valid_d  = 1'b1;
                            tx_sr_d  = w_tx_load;
                            tx_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.bit_req) begin
                        tx_sr_d = {tx_sr_q[c_NBITS-2:0], 1'b0};
                        if (tx_cnt_q == c_TX_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            tx_cnt_d = tx_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign bus.sample_ctl   = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) ? w_onehot : '0;
    assign bus.sample_clk   = ((state_q == ST_SHIFT) && (div_q <= c_DIV_SHIFT)) ? w_onehot : '0;
    assign bus.bitsrc       = (state_q == ST_HOLD) ? tx_sr_q[c_NBITS-1] : 1'b0;
    assign bus.datadone     = done_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_chan  = chan_q;
    assign bus.sel_err      = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_sample_mux.sv
// ============================================================================
// Module   : tb_sensor_sample_mux
// Purpose  : Directed self-checking bench for sensor_sample_mux (NCH=4 main
//            instance plus NCH=3 / NCH=6 instances for channel-range checks).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sensor_sample_mux;

    logic clk;
    logic reset;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] sb_word[$];
    logic        sb_bit[$];

    sensor_sample_mux_if #(.NCH(4), .SAMPLE_W(16), .SEL_W(2)) bus  ();
    sensor_sample_mux_if #(.NCH(3), .SAMPLE_W(16), .SEL_W(2)) bus3 ();
    sensor_sample_mux_if #(.NCH(6), .SAMPLE_W(16), .SEL_W(3)) bus6 ();

    sensor_sample_mux #(.NCH(4), .SAMPLE_W(16), .CLKDIV(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    sensor_sample_mux #(.NCH(3), .SAMPLE_W(16), .CLKDIV(4)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    sensor_sample_mux #(.NCH(6), .SAMPLE_W(16), .CLKDIV(4)) u_dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a capture on channel ch, streams word MSB first on each rising
    // sample_clk, and runs until sample_valid or until cycle stop_cyc.
    task automatic run_capture(input int ch, input logic [15:0] word, input int stop_cyc,
                               output int lat, output int pulses);
        logic       prev_clk;
        logic [3:0] onehot;
        int         stray;
        onehot   = 4'(1) << ch;
        lat      = -1;
        pulses   = 0;
        stray    = 0;
        prev_clk = 1'b0;
        bus.chan_sel = 2'(ch);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == 1) begin
                check("ctl_setup",  32'(bus.sample_ctl), 32'(onehot));
                check("busy_setup", 32'(bus.busy), 32'd1);
                check("valid_clr",  32'(bus.sample_valid), 32'd0);
                check("done_clr",   32'(bus.datadone), 32'd0);
            end
            if (cyc == 4) check("clk_setup_end", 32'(bus.sample_clk), 32'd0);
            if (cyc == 5) check("clk_shift_first", 32'(bus.sample_clk), 32'(onehot));
            if (cyc == 11) begin
                check("start_ignored_chan", 32'(bus.sample_chan), 32'(ch));
                check("start_ignored_err",  32'(bus.sel_err), 32'd0);
            end
            if (((bus.sample_clk | bus.sample_ctl) & ~onehot) != 4'd0) stray++;
            if (bus.sample_clk[ch] && !prev_clk) begin
                if (pulses < 16) bus.sample_datain[ch] = word[15 - pulses];
                pulses++;
            end
            prev_clk = bus.sample_clk[ch];
            if (cyc == stop_cyc) break;
            if (bus.sample_valid) begin
                lat = cyc;
                break;
            end
            bus.start    = (cyc == 10);
            bus.chan_sel = 2'((ch + 1) % 4);
            tick();
            bus.start = 1'b0;
        end
        check("stray_channel", 32'(stray), 32'd0);
    endtask

    // Drains the held sample through bit_req, one idle cycle between requests.
    task automatic run_tx(input logic [15:0] word);
        int   n;
        logic exp;
        for (int i = 15; i >= 0; i--) sb_bit.push_back(word[i]);
`ifdef SENSOR_SAMPLE_PARITY_EN
        sb_bit.push_back(^word);
`endif
        n = sb_bit.size();
        for (int i = 0; i < n; i++) begin
            exp = sb_bit.pop_front();
            check("bitsrc", 32'(bus.bitsrc), 32'(exp));
            check("datadone_early", 32'(bus.datadone), 32'd0);
            bus.bit_req = 1'b1;
            tick();
            bus.bit_req = 1'b0;
            if (i < n - 1) tick();
        end
        check("datadone",   32'(bus.datadone), 32'd1);
        check("busy_done",  32'(bus.busy), 32'd0);
        check("valid_held", 32'(bus.sample_valid), 32'd1);
        check("data_held",  32'(bus.sample_data), 32'(word));
        check("bitsrc_done", 32'(bus.bitsrc), 32'd0);
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [15:0] exp_partial;

        reset = 1'b0;
        bus.start = 1'b0;  bus.chan_sel = '0;  bus.abort = 1'b0;  bus.sample_datain = '0;  bus.bit_req = 1'b0;
        bus3.start = 1'b0; bus3.chan_sel = '0; bus3.abort = 1'b0; bus3.sample_datain = '0; bus3.bit_req = 1'b0;
        bus6.start = 1'b0; bus6.chan_sel = '0; bus6.abort = 1'b0; bus6.sample_datain = '0; bus6.bit_req = 1'b0;
        repeat (3) tick();

        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_data",  32'(bus.sample_data), 32'd0);
        check("rst_chan",  32'(bus.sample_chan), 32'd0);
        check("rst_ctl",   32'(bus.sample_ctl), 32'd0);
        check("rst_clk",   32'(bus.sample_clk), 32'd0);
        check("rst_bit",   32'(bus.bitsrc), 32'd0);
        check("rst_done",  32'(bus.datadone), 32'd0);
        check("rst_err",   32'(bus.sel_err), 32'd0);
        reset = 1'b1;
        tick();

        // out-of-range channel on the NCH=3 build
        bus3.chan_sel = 2'd3;
        bus3.start    = 1'b1;
        tick();
        bus3.start = 1'b0;
        check("n3_sel_err",  32'(bus3.sel_err), 32'd1);
        check("n3_busy",     32'(bus3.busy), 32'd0);
        tick();
        check("n3_sel_err_pulse", 32'(bus3.sel_err), 32'd0);
        check("n3_busy_after",    32'(bus3.busy), 32'd0);

        // top channel is legal on the NCH=6 build
        bus6.chan_sel = 3'd5;
        bus6.start    = 1'b1;
        tick();
        bus6.start = 1'b0;
        check("n6_busy",    32'(bus6.busy), 32'd1);
        check("n6_sel_err", 32'(bus6.sel_err), 32'd0);
        check("n6_chan",    32'(bus6.sample_chan), 32'd5);
        check("n6_ctl",     32'(bus6.sample_ctl), 32'h20);
        bus6.abort = 1'b1;
        tick();
        bus6.abort = 1'b0;
        check("n6_abort_busy", 32'(bus6.busy), 32'd0);

        // channel 2 capture and replay
        sb_word.push_back(16'hA5C3);
        run_capture(2, 16'hA5C3, 0, lat, pulses);
        check("latency_ch2", 32'(lat), 32'd69);
        check("pulses_ch2",  32'(pulses), 32'd16);
        check("data_ch2",    32'(bus.sample_data), 32'(sb_word.pop_front()));
        check("chan_ch2",    32'(bus.sample_chan), 32'd2);
        check("hold_ctl",    32'(bus.sample_ctl), 32'd0);
        check("hold_clk",    32'(bus.sample_clk), 32'd0);
        check("hold_busy",   32'(bus.busy), 32'd1);
        run_tx(16'hA5C3);
        bus.bit_req = 1'b1;
        tick();
        bus.bit_req = 1'b0;
        check("bitreq_in_done", 32'(bus.datadone), 32'd1);

        // abort together with start mid-shift; eight bits of the new word are in
        exp_partial = 16'((16'hA5C3 << 8) | (16'h3C96 >> 8));
        run_capture(1, 16'h3C96, 35, lat, pulses);
        bus.abort    = 1'b1;
        bus.start    = 1'b1;
        bus.chan_sel = 2'd3;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_ctl",   32'(bus.sample_ctl), 32'd0);
        check("abort_clk",   32'(bus.sample_clk), 32'd0);
        check("abort_valid", 32'(bus.sample_valid), 32'd0);
        check("abort_done",  32'(bus.datadone), 32'd0);
        check("abort_chan",  32'(bus.sample_chan), 32'd1);
        check("abort_data",  32'(bus.sample_data), 32'(exp_partial));
        tick();
        check("abort_start_dropped", 32'(bus.busy), 32'd0);

        // reset while holding an all-ones sample
        sb_word.push_back(16'hFFFF);
        run_capture(3, 16'hFFFF, 0, lat, pulses);
        check("latency_ch3", 32'(lat), 32'd69);
        check("data_ch3",    32'(bus.sample_data), 32'(sb_word.pop_front()));
        check("hold_msb",    32'(bus.bitsrc), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_data",  32'(bus.sample_data), 32'd0);
        check("midrst_bit",   32'(bus.bitsrc), 32'd0);
        check("midrst_done",  32'(bus.datadone), 32'd0);
        check("midrst_valid", 32'(bus.sample_valid), 32'd0);
        check("midrst_busy",  32'(bus.busy), 32'd0);

        sb_word.push_back(16'h1234);
        run_capture(0, 16'h1234, 0, lat, pulses);
        check("latency_ch0", 32'(lat), 32'd69);
        check("data_ch0",    32'(bus.sample_data), 32'(sb_word.pop_front()));
        run_tx(16'h1234);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sensor_sample_mux.md
SENSOR_SAMPLE_MUX -- requirements
Module: sensor_sample_mux

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of serial sample sources (legal 2..8).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning bits captured per sample (legal 4..32).
REQ-003 SHALL have parameter CLKDIV, default 4, meaning clk cycles per sample_clk period (even, legal 2..16).
REQ-004 SHALL have derived parameter SEL_W = max(1, ceil(log2(NCH))), meaning channel index width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle sample request.
REQ-008 SHALL have port chan_sel  input  SEL_W  channel requested with start.
REQ-009 SHALL have port abort  input  1  cancels any operation in progress.
REQ-010 SHALL have port sample_ctl  output  NCH  per-channel conversion enable, one-hot or zero.
REQ-011 SHALL have port sample_clk  output  NCH  per-channel serial clock, one-hot or zero.
REQ-012 SHALL have port sample_datain  input  NCH  per-channel serial data, MSB first.
REQ-013 SHALL have port bit_req  input  1  one-cycle strobe from tx sequencer requesting the next bit.
REQ-014 SHALL have port bitsrc  output  1  current serial tx bit.
REQ-015 SHALL have port datadone  output  1  all bits of the sample consumed.
REQ-016 SHALL have ports busy (1), sample_valid (1), sample_data (SAMPLE_W), sample_chan (SEL_W), sel_err (1), all outputs.

Function
REQ-017 SHALL implement FSM IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-018 SHALL, in IDLE or DONE, accept start with chan_sel < NCH: latch the channel into sample_chan, clear datadone and sample_valid, and enter SETUP the next cycle.
REQ-019 SHALL, on start with chan_sel >= NCH, stay in its current state and pulse sel_err high for exactly one cycle.
REQ-020 SHALL ignore start in SETUP, SHIFT and HOLD; sel_err stays low.
REQ-021 SHALL drive busy=1 in SETUP, SHIFT and HOLD, and 0 otherwise.
REQ-022 SHALL assert sample_ctl[sample_chan] throughout SETUP and SHIFT and keep all other sample_ctl bits 0.
REQ-023 SHALL hold SETUP for CLKDIV cycles, then enter SHIFT.
REQ-024 SHALL, in SHIFT, produce SAMPLE_W periods of CLKDIV cycles on sample_clk[sample_chan]: high for the first CLKDIV/2 cycles, low for the rest.
REQ-025 SHALL shift sample_datain[sample_chan] into sample_data (MSB first) on the last high cycle of each period.
REQ-026 SHALL enter HOLD after SAMPLE_W periods; sample_valid=1, sample_ctl=0 and sample_clk=0 in the same cycle.
REQ-027 SHALL give latency from accepted start (cycle 0) to sample_valid=1 of exactly 1+CLKDIV*(SAMPLE_W+1) cycles.
REQ-028 SHALL, in HOLD, present the MSB on bitsrc; each bit_req advances bitsrc to the next bit in the following cycle.
REQ-029 SHALL, on the bit_req that consumes the last bit, enter DONE: datadone=1 and busy=0; sample_valid and sample_data are held.
REQ-030 SHALL ignore bit_req outside HOLD.
REQ-031 SHALL take abort as highest priority: from any state it enters IDLE next cycle, with sample_ctl, sample_clk, busy, datadone and sample_valid all 0 and sample_data retained.
REQ-032 SHALL give abort priority over start when both occur in the same cycle; the start is dropped.
REQ-033 SHALL drive bitsrc=0 outside HOLD.

Reset
REQ-034 SHALL, when reset=0 at a clk edge, enter IDLE and clear all outputs to 0 (sample_data=0, sample_chan=0, all counters zeroed).
REQ-035 SHALL treat reset mid-operation like abort, additionally clearing sample_data.

Configuration
REQ-036 SHALL use macro SENSOR_SAMPLE_PARITY_EN: when defined, append an even-parity bit of sample_data after the LSB (SAMPLE_W+1 bits serialized); datadone asserts only after the parity bit is consumed.
REQ-037 SHALL, without SENSOR_SAMPLE_PARITY_EN, serialize exactly SAMPLE_W bits and contain no parity logic.

Verification (NCH=4, SAMPLE_W=16, CLKDIV=4)
REQ-038 SHALL cover: start with chan_sel=2, sample_datain[2] streams 0xA5C3 -> sample_ctl=4'b0100, 16 pulses on sample_clk[2], sample_valid at cycle 69, sample_data=0xA5C3.
REQ-039 SHALL cover: after REQ-038, 16 bit_req strobes -> bitsrc sequence 1010010111000011, datadone=1 after the 16th; with SENSOR_SAMPLE_PARITY_EN a 17th bit 0 precedes datadone.
REQ-040 SHALL cover: start with chan_sel=5 on an NCH=6 build, and chan_sel=3 on an NCH=3 build -> sel_err pulses one cycle on the NCH=3 build, busy stays 0.
REQ-041 SHALL cover: abort asserted at cycle 30 of SHIFT together with start -> IDLE next cycle, all sample_ctl/sample_clk=0, start dropped.
REQ-042 SHALL cover: reset=0 in HOLD after capturing 0xFFFF -> sample_data=0, bitsrc=0, datadone=0; a subsequent start on channel 0 completes normally.
